// File: rtl/ic_pkg.sv
// Shared constants for the interrupt controller: FSM state encodings, register
// addresses on the bus-connect data path and ICTL bit positions.
package ic_pkg;

   // FSM state encodings (also visible in ICTL[2:1])
   localparam logic [1:0] IC_IDLE    = 2'b00;
   localparam logic [1:0] IC_REQ     = 2'b01;
   localparam logic [1:0] IC_SERVICE = 2'b10;

   // Register addresses
   localparam logic [1:0] IC_IMASK = 2'd0;
   localparam logic [1:0] IC_IRPTL = 2'd1;
   localparam logic [1:0] IC_IEDGE = 2'd2;
   localparam logic [1:0] IC_ICTL  = 2'd3;

   // ICTL bit positions
   localparam int unsigned ICTL_GIE       = 0;
   localparam int unsigned ICTL_STATE_LSB = 1;
   localparam int unsigned ICTL_VEC_LSB   = 3;

endpackage

// File: rtl/ic_sync_edge.sv
// One interrupt source: two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk      in   core clock
//   reset    in   asynchronous active-low reset
//   src      in   raw source, asynchronous to clk
//   sync_lvl out  synchronised level (second flop)
//   rise     out  one-cycle pulse when sync_lvl goes 0 -> 1
module ic_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic src,
   output logic sync_lvl,
   output logic rise
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= src;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_lvl = sync_q;
   assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller driving the core's single interrupt input. Synchronises
// NUM_SRC sources, latches them as pending, masks them, picks the lowest index and
// tracks the granted request through ack and RTI.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   irq_src                  raw external sources
//   ps_ic_wrt_en/_wrt_add    register write strobe and address, data on bc_dt
//   ps_ic_rd_add, ic_bc_dt   register read address, combinational read data
//   ps_ic_ack, ps_ic_rti     vector accepted / return from interrupt pulses
//   interrupt, ic_ps_vec     registered request and granted vector
module irq_ctrl #(
   parameter int unsigned NUM_SRC     = 8,
   parameter int unsigned RF_DATASIZE = 16,
   parameter int unsigned VEC_WIDTH   = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     irq_src,
   input  logic                   ps_ic_wrt_en,
   input  logic [1:0]             ps_ic_wrt_add,
   input  logic [1:0]             ps_ic_rd_add,
   input  logic [RF_DATASIZE-1:0] bc_dt,
   output logic [RF_DATASIZE-1:0] ic_bc_dt,
   input  logic                   ps_ic_ack,
   input  logic                   ps_ic_rti,
   output logic                   interrupt,
   output logic [VEC_WIDTH-1:0]   ic_ps_vec
);

   import ic_pkg::*;

   logic [NUM_SRC-1:0]   imask_q, imask_d, iedge_q, iedge_d, irptl_q, irptl_d;
   logic [NUM_SRC-1:0]   sync_lvl, rise, clr, req;
   logic                 gie_q, gie_d;
   logic [1:0]           state_q, state_d;
   logic [VEC_WIDTH-1:0] vec_q, vec_d, win_idx;
   logic                 interrupt_q, interrupt_d;
   logic                 unused_bc_dt;

   assign unused_bc_dt = ^bc_dt;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      ic_sync_edge u_sync (
         .clk      (clk),
         .reset    (reset),
         .src      (irq_src[i]),
         .sync_lvl (sync_lvl[i]),
         .rise     (rise[i])
      );
   end

   // Register writes
   always_comb begin
      imask_d = imask_q;
      iedge_d = iedge_q;
      gie_d   = gie_q;
      if (ps_ic_wrt_en) begin
         case (ps_ic_wrt_add)
            IC_IMASK: imask_d = bc_dt[NUM_SRC-1:0];
            IC_IEDGE: iedge_d = bc_dt[NUM_SRC-1:0];
            IC_ICTL:  gie_d   = bc_dt[ICTL_GIE];
            default:  ;
         endcase
      end
   end

   // Pending: edge sources are sticky with set-over-clear; level sources follow the
   // synchronised input and ignore W1C and ack.
   always_comb begin
      clr = '0;
      if (ps_ic_wrt_en && ps_ic_wrt_add == IC_IRPTL) clr = bc_dt[NUM_SRC-1:0];
      if (state_q == IC_REQ && ps_ic_ack) clr[vec_q] = 1'b1;
      irptl_d = (iedge_q & ((irptl_q & ~clr) | rise)) | (~iedge_q & sync_lvl);
   end

   assign req = irptl_q & imask_q & {NUM_SRC{gie_q}};

   // Fixed priority: scan downwards so the lowest set index wins
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) win_idx = VEC_WIDTH'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      case (state_q)
         IC_IDLE: begin
            if (|req) begin
               state_d = IC_REQ;
               vec_d   = win_idx;
            end
         end
         IC_REQ: begin
            // ack wins over a simultaneous cancel
            if (ps_ic_ack)         state_d = IC_SERVICE;
            else if (!req[vec_q])  state_d = IC_IDLE;
         end
         IC_SERVICE: begin
            if (ps_ic_rti) state_d = IC_IDLE;
         end
         default: state_d = IC_IDLE;
      endcase
      interrupt_d = (state_d == IC_REQ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         imask_q     <= '0;
         iedge_q     <= '0;
         irptl_q     <= '0;
         gie_q       <= 1'b0;
         state_q     <= IC_IDLE;
         vec_q       <= '0;
         interrupt_q <= 1'b0;
      end else begin
         imask_q     <= imask_d;
         iedge_q     <= iedge_d;
         irptl_q     <= irptl_d;
         gie_q       <= gie_d;
         state_q     <= state_d;
         vec_q       <= vec_d;
         interrupt_q <= interrupt_d;
      end
   end

   assign interrupt = interrupt_q;
   assign ic_ps_vec = vec_q;

   // Register read mux; unused bits read 0
   always_comb begin
      ic_bc_dt = '0;
      case (ps_ic_rd_add)
         IC_IMASK: ic_bc_dt[NUM_SRC-1:0] = imask_q;
         IC_IRPTL: ic_bc_dt[NUM_SRC-1:0] = irptl_q;
         IC_IEDGE: ic_bc_dt[NUM_SRC-1:0] = iedge_q;
         IC_ICTL: begin
            ic_bc_dt[ICTL_GIE]                   = gie_q;
            ic_bc_dt[ICTL_STATE_LSB +: 2]        = state_q;
            ic_bc_dt[ICTL_VEC_LSB +: VEC_WIDTH]  = vec_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: priority, hold, mask/cancel, level mode,
// same-cycle collisions and reset during service.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  irq_src;
   logic        ps_ic_wrt_en;
   logic [1:0]  ps_ic_wrt_add;
   logic [1:0]  ps_ic_rd_add;
   logic [15:0] bc_dt;
   logic [15:0] ic_bc_dt;
   logic        ps_ic_ack;
   logic        ps_ic_rti;
   logic        interrupt;
   logic [2:0]  ic_ps_vec;

   int checks = 0;
   int errors = 0;

   irq_ctrl #(
      .NUM_SRC     (8),
      .RF_DATASIZE (16),
      .VEC_WIDTH   (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_src       (irq_src),
      .ps_ic_wrt_en  (ps_ic_wrt_en),
      .ps_ic_wrt_add (ps_ic_wrt_add),
      .ps_ic_rd_add  (ps_ic_rd_add),
      .bc_dt         (bc_dt),
      .ic_bc_dt      (ic_bc_dt),
      .ps_ic_ack     (ps_ic_ack),
      .ps_ic_rti     (ps_ic_rti),
      .interrupt     (interrupt),
      .ic_ps_vec     (ic_ps_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges; inputs and samples sit 1ns after the edge
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      ps_ic_wrt_en  = 1'b1;
      ps_ic_wrt_add = a;
      bc_dt         = d;
      cyc(1);
      ps_ic_wrt_en  = 1'b0;
      bc_dt         = '0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
      ps_ic_rd_add = a;
      #1;
      check(tag, ic_bc_dt, exp);
   endtask

   task automatic pulse_src(input logic [7:0] m);
      irq_src = m;
      cyc(1);
      irq_src = '0;
   endtask

   task automatic do_ack;
      ps_ic_ack = 1'b1;
      cyc(1);
      ps_ic_ack = 1'b0;
   endtask

   task automatic do_rti;
      ps_ic_rti = 1'b1;
      cyc(1);
      ps_ic_rti = 1'b0;
   endtask

   function automatic logic [15:0] ictl(input logic gie, input logic [1:0] st,
                                         input logic [2:0] vec);
      return {10'b0, vec, st, gie};
   endfunction

   initial begin
      reset = 1'b0;  irq_src = '0;  ps_ic_wrt_en = 1'b0;  ps_ic_wrt_add = '0;
      ps_ic_rd_add = '0;  bc_dt = '0;  ps_ic_ack = 1'b0;  ps_ic_rti = 1'b0;
      cyc(2);
      check("rst_int", 16'(interrupt), 16'h0);
      check("rst_vec", 16'(ic_ps_vec), 16'h0);
      check_reg("rst_imask", 2'd0, 16'h0);
      check_reg("rst_ictl", 2'd3, 16'h0);
      reset = 1'b1;
      cyc(1);

      // 1. single edge on src 5
      wr(2'd0, 16'h00FF);
      wr(2'd2, 16'h00FF);
      wr(2'd3, 16'h0001);
      check_reg("t1_imask", 2'd0, 16'h00FF);
      pulse_src(8'h20);
      cyc(1);
      check("t1_int_early", 16'(interrupt), 16'h0);
      cyc(1);
      check("t1_int_k2", 16'(interrupt), 16'h0);
      check_reg("t1_irptl", 2'd1, 16'h0020);
      cyc(1);
      check("t1_int", 16'(interrupt), 16'h1);
      check("t1_vec", 16'(ic_ps_vec), 16'h5);
      check_reg("t1_ictl_req", 2'd3, ictl(1'b1, 2'b01, 3'd5));
      do_ack();
      check("t1_int_ack", 16'(interrupt), 16'h0);
      check_reg("t1_irptl_ack", 2'd1, 16'h0000);
      check_reg("t1_ictl_svc", 2'd3, ictl(1'b1, 2'b10, 3'd5));
      do_rti();
      check_reg("t1_ictl_idle", 2'd3, ictl(1'b1, 2'b00, 3'd5));

      // 2. priority and hold
      pulse_src(8'h44);
      cyc(3);
      check("t2_int", 16'(interrupt), 16'h1);
      check("t2_vec", 16'(ic_ps_vec), 16'h2);
      pulse_src(8'h02);
      cyc(2);
      check_reg("t2_irptl", 2'd1, 16'h0046);
      check("t2_vec_hold", 16'(ic_ps_vec), 16'h2);
      check("t2_int_hold", 16'(interrupt), 16'h1);
      do_ack();
      check_reg("t2_irptl_ack", 2'd1, 16'h0042);
      do_rti();
      check("t2_int_rti", 16'(interrupt), 16'h0);
      cyc(1);
      check("t2_int_v1", 16'(interrupt), 16'h1);
      check("t2_vec_v1", 16'(ic_ps_vec), 16'h1);
      do_ack();
      do_rti();
      cyc(1);
      check("t2_vec_v6", 16'(ic_ps_vec), 16'h6);
      do_ack();
      do_rti();
      check_reg("t2_irptl_end", 2'd1, 16'h0000);

      // 3. masking and cancel
      wr(2'd0, 16'h0000);
      pulse_src(8'h08);
      cyc(3);
      check("t3_int_masked", 16'(interrupt), 16'h0);
      check_reg("t3_irptl", 2'd1, 16'h0008);
      wr(2'd0, 16'h0008);
      cyc(1);
      check("t3_int", 16'(interrupt), 16'h1);
      check("t3_vec", 16'(ic_ps_vec), 16'h3);
      wr(2'd0, 16'h0000);
      cyc(1);
      check("t3_int_cancel", 16'(interrupt), 16'h0);
      check_reg("t3_ictl_cancel", 2'd3, ictl(1'b1, 2'b00, 3'd3));
      wr(2'd1, 16'h0008);
      check_reg("t3_irptl_w1c", 2'd1, 16'h0000);

      // 4. level mode
      wr(2'd0, 16'h00FF);
      wr(2'd2, 16'h0000);
      irq_src = 8'h10;
      cyc(4);
      check("t4_int", 16'(interrupt), 16'h1);
      check("t4_vec", 16'(ic_ps_vec), 16'h4);
      wr(2'd1, 16'h0010);
      check_reg("t4_irptl_w1c", 2'd1, 16'h0010);
      do_ack();
      check_reg("t4_ictl_svc", 2'd3, ictl(1'b1, 2'b10, 3'd4));
      check_reg("t4_irptl_ack", 2'd1, 16'h0010);
      do_rti();
      check("t4_int_rti", 16'(interrupt), 16'h0);
      cyc(1);
      check("t4_int_rereq", 16'(interrupt), 16'h1);
      irq_src = '0;
      cyc(4);
      check("t4_int_drop", 16'(interrupt), 16'h0);
      check_reg("t4_irptl_drop", 2'd1, 16'h0000);

      // 5. same-cycle collisions
      wr(2'd2, 16'h00FF);
      wr(2'd0, 16'h0000);
      pulse_src(8'h01);
      cyc(1);
      wr(2'd1, 16'h0001);
      check_reg("t5_set_wins", 2'd1, 16'h0001);
      wr(2'd1, 16'h0001);
      check_reg("t5_w1c", 2'd1, 16'h0000);
      wr(2'd0, 16'h00FF);
      pulse_src(8'h01);
      cyc(3);
      check("t5_int", 16'(interrupt), 16'h1);
      wr(2'd0, 16'h0000);
      check("t5_int_still", 16'(interrupt), 16'h1);
      do_ack();
      check_reg("t5_ack_wins", 2'd3, ictl(1'b1, 2'b10, 3'd0));
      check("t5_int_ack", 16'(interrupt), 16'h0);
      do_rti();

      // 6. reset mid-service
      wr(2'd0, 16'h00FF);
      pulse_src(8'h80);
      cyc(3);
      check("t6_vec", 16'(ic_ps_vec), 16'h7);
      do_ack();
      pulse_src(8'h81);
      cyc(2);
      check_reg("t6_irptl", 2'd1, 16'h0081);
      check_reg("t6_ictl_svc", 2'd3, ictl(1'b1, 2'b10, 3'd7));
      reset = 1'b0;
      #1;
      check("t6_rst_int", 16'(interrupt), 16'h0);
      check("t6_rst_vec", 16'(ic_ps_vec), 16'h0);
      check_reg("t6_rst_imask", 2'd0, 16'h0000);
      check_reg("t6_rst_irptl", 2'd1, 16'h0000);
      check_reg("t6_rst_iedge", 2'd2, 16'h0000);
      check_reg("t6_rst_ictl", 2'd3, 16'h0000);
      cyc(1);
      reset = 1'b1;
      irq_src = 8'h01;
      cyc(4);
      check("t6_no_req", 16'(interrupt), 16'h0);
      check_reg("t6_level_after", 2'd1, 16'h0001);
      irq_src = '0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
